// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed big-endian byte stream, writes
// each assembled 32-bit word into instruction memory, then holds the core in
// reset for RST_HOLD cycles before releasing it.
module prog_loader #(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 10,
    parameter int RST_HOLD  = 2
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [8:0]        words_loaded
);

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    // Last HOLD count value before release; RST_HOLD of 0 still costs one cycle.
    localparam logic [31:0] HOLD_LAST = (RST_HOLD > 0) ? 32'(RST_HOLD - 1) : 32'd0;

    state_t              r_state;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;
    logic [31:0]         r_count;
    logic [31:0]         r_hold_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_cpu_reset;
    logic                r_done;
    logic                r_err;
    logic [8:0]          r_words;

    logic                w_accept;
    logic [31:0]         w_word;
    logic [8:0]          w_next_words;
    logic [31:0]         w_addr_full;

    // Only LEN and LOAD consume bytes; reset forces ready low immediately.
    assign in_ready     = reset && (r_state == S_LEN || r_state == S_LOAD);
    assign w_accept     = in_valid && in_ready;
    // Word as it will look once the current byte lands (MSB first).
    assign w_word       = {r_shift, in_data};
    assign w_next_words = r_words + 9'd1;
    assign w_addr_full  = {21'd0, r_words, 2'b00};

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

    // Loader FSM with all outputs registered.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            r_state     <= S_LEN;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 24'd0;
            r_count     <= 32'd0;
            r_hold_cnt  <= 32'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= 9'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_accept) begin
                        r_shift    <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_count <= w_word;
                            if (w_word == 32'd0) begin
                                r_state <= S_HOLD;
                            end else if (w_word > 32'(MAX_WORDS)) begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_shift    <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_addr_full[ADDR_W-1:0];
                            r_wdata <= w_word;
                            r_words <= w_next_words;
                            if ({23'd0, w_next_words} == r_count) begin
                                r_state <= S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt >= HOLD_LAST) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_LEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized byte streams against a stream-level model.
module tb_prog_loader;

    localparam int MAXW  = 256;
    localparam int AW    = 10;
    localparam int RHOLD = 2;

    logic          Clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          err;
    logic [8:0]    words_loaded;

    prog_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW), .RST_HOLD(RHOLD)) dut (
        .Clk(Clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
        .err(err), .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream-level model: counts accepted bytes, derives the header, the
    // completed words and the cycles elapsed since the last word.
    logic [7:0]    m_bytes [0:1039];
    int            m_acc;
    int            m_words;
    int            m_since;
    bit            m_err;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_n;
    bit            m_rdy;
    int            m_w;
    bit            chk_en = 0;

    always @(posedge Clk) begin
        if (!reset) begin
            m_acc = 0; m_words = 0; m_since = -1; m_err = 0; m_we = 0;
            m_addr = '0; m_wdata = 32'd0; m_n = 32'd0;
        end else begin
            m_rdy = !m_err && (m_since < 0);
            m_we = 0;
            if (in_valid && m_rdy) begin
                m_bytes[m_acc] = in_data;
                m_acc++;
                if (m_acc == 4) begin
                    m_n = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    if (m_n == 32'd0) m_since = 0;
                    else if (m_n > 32'(MAXW)) m_err = 1;
                end else if (m_acc > 4 && (m_acc % 4) == 0) begin
                    m_w     = (m_acc - 4) / 4 - 1;
                    m_we    = 1;
                    m_addr  = AW'(4 * m_w);
                    m_wdata = {m_bytes[m_acc-4], m_bytes[m_acc-3], m_bytes[m_acc-2], m_bytes[m_acc-1]};
                    m_words = m_w + 1;
                    if (32'(m_words) == m_n) m_since = 0;
                end
            end else if (m_since >= 0 && m_since < RHOLD) begin
                m_since++;
            end
        end
    end

    // Write log and release timing, observed from the DUT pins.
    logic [63:0] wlog[$];
    time         t_last_we;
    time         t_fall;
    logic        prev_cpu = 1'b1;

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(reset && !m_err && m_since < 0));
            chk("imem_we", 64'(imem_we), 64'(m_we));
            chk("imem_addr", 64'(imem_addr), 64'(m_addr));
            chk("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
            chk("cpu_reset", 64'(cpu_reset), 64'(!(m_since >= RHOLD)));
            chk("done", 64'(done), 64'(m_since >= RHOLD));
            chk("err", 64'(err), 64'(m_err));
            chk("words_loaded", 64'(words_loaded), 64'(m_words));
            if (imem_we) begin
                wlog.push_back({32'(imem_addr), imem_wdata});
                t_last_we = $time;
            end
            if (prev_cpu && !cpu_reset) t_fall = $time;
            prev_cpu = cpu_reset;
        end
    end

    typedef logic [7:0] byte_q_t[$];

    // mode 0: valid every cycle, 1: valid every other cycle, 2: random gaps
    task automatic send(input byte_q_t q, input int mode, input int maxcyc, input bit expect_all);
        int idx = 0;
        int cyc = 0;
        while (idx < q.size() && cyc < maxcyc) begin
            @(posedge Clk); #2;
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2) == 0;
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_data = in_valid ? q[idx] : 8'($urandom);
            #7;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(posedge Clk); #2;
        in_valid = 1'b0;
        if (expect_all && idx < q.size()) begin
            n_cmp++; n_fail++;
            $display("FAIL stream_timeout: accepted %0d of %0d bytes", idx, q.size());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge Clk); #2;
        reset = 1'b0; in_valid = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge Clk); #2;
        reset = 1'b1;
        wlog.delete();
        prev_cpu = 1'b1;
    endtask

    function automatic byte_q_t hdr(input int n);
        byte_q_t q;
        q.push_back(8'(n >> 24)); q.push_back(8'(n >> 16));
        q.push_back(8'(n >> 8));  q.push_back(8'(n));
        return q;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        byte_q_t q;
        reset = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        @(posedge Clk); #2;
        chk_en = 1;
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        reset = 1'b1;

        // Two-word program, continuous valid
        q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        send(q, 0, 40, 1);
        idle(5);
        chk("t1_nwrites", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("t1_w0", wlog[0], {32'h0, 32'h20080005});
            chk("t1_w1", wlog[1], {32'h4, 32'h01095020});
        end
        chk("t1_release_delay", 64'((t_fall - t_last_we) / 10), 64'd2);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_words", 64'(words_loaded), 64'd2);

        // Empty program
        do_reset();
        send(hdr(0), 0, 20, 1);
        idle(4);
        chk("t2_nwrites", 64'(wlog.size()), 64'd0);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_cpu_reset", 64'(cpu_reset), 64'd0);

        // Oversized header, trailing bytes ignored
        do_reset();
        q = hdr(257);
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        send(q, 0, 20, 0);
        idle(3);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("t3_nwrites", 64'(wlog.size()), 64'd0);

        // One word with valid toggling
        do_reset();
        q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04};
        send(q, 1, 40, 1);
        idle(4);
        chk("t4_nwrites", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("t4_w0", wlog[0], {32'h0, 32'h8C010004});
        chk("t4_done", 64'(done), 64'd1);

        // Reset mid-load, then a fresh one-word load
        do_reset();
        q = hdr(3);
        q = {q, rand_bytes(6)};
        send(q, 2, 80, 1);
        do_reset();
        chk("t5_words_after_rst", 64'(words_loaded), 64'd0);
        chk("t5_cpu_after_rst", 64'(cpu_reset), 64'd1);
        q = hdr(1);
        q = {q, rand_bytes(4)};
        send(q, 2, 80, 1);
        idle(4);
        chk("t5_nwrites", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("t5_addr", wlog[0][63:32], 64'h0);

        // Full 256-word load, then extra bytes in RUN
        do_reset();
        q = hdr(256);
        q = {q, rand_bytes(1024)};
        send(q, 2, 6000, 1);
        idle(4);
        send(rand_bytes(10), 0, 12, 0);
        chk("t6_nwrites", 64'(wlog.size()), 64'd256);
        if (wlog.size() == 256) chk("t6_last_addr", wlog[255][63:32], 64'h3FC);
        chk("t6_words", 64'(words_loaded), 64'd256);
        chk("t6_done", 64'(done), 64'd1);

        // Random programs, some cut short by reset
        for (int t = 0; t < 8; t++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 12);
            q = hdr(n);
            q = {q, rand_bytes(4 * n)};
            if ($urandom_range(0, 2) == 0) begin
                send(q[0:$urandom_range(1, q.size() - 2)], $urandom_range(0, 2), 400, 1);
                do_reset();
                q = hdr(n);
                q = {q, rand_bytes(4 * n)};
            end
            send(q, $urandom_range(0, 2), 400, 1);
            idle(RHOLD + 3);
            chk("rnd_nwrites", 64'(wlog.size()), 64'(n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
